ysyx_24080006_axi_sram: RTL and testbench
=========================================

YSYX_24080006_AXI_SRAM -- requirements
Module: ysyx_24080006_axi_sram

Interface
REQ-001 Parameter MEM_WORDS, default 1024, memory depth in 32-bit words (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-003 Parameter RD_LAT, default 1, extra wait cycles between AR accept and rvalid (0..15).
REQ-004 Parameter WR_LAT, default 1, extra wait cycles between AW+W capture and bvalid (0..15).
REQ-005 clock  input  1  single clock; all state updates on posedge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 w_m2s  input  axi_w_m2s_t  write channels from master (aw*, w*, bready).
REQ-008 w_s2m  output  axi_w_s2m_t  awready, wready, bvalid, bresp, bid to master.
REQ-009 r_m2s  input  axi_r_m2s_t  read channels from master (ar*, rready).
REQ-010 r_s2m  output  axi_r_s2m_t  arready, rvalid, rdata, rresp, rlast, rid to master.

Function
REQ-011 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-012 R_IDLE: arvalid&arready -> latch araddr, arid, arlen; go R_WAIT if RD_LAT>0, else R_RESP.
REQ-013 R_WAIT: down-counter loaded with RD_LAT-1; at zero go R_RESP.
REQ-014 On entry to R_RESP: rvalid=1, rlast=1, rid=latched arid, rdata=full aligned word mem[(araddr-BASE_ADDR)>>2], unshifted (master extracts bytes).
REQ-015 rresp=2'b00 OKAY; 2'b11 DECERR with rdata=0 if araddr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS); 2'b10 SLVERR if arlen!=0.
REQ-016 R_RESP: rvalid, rdata, rresp, rid held stable until rvalid&rready; then R_IDLE, rvalid=0 next cycle.
REQ-017 Read latency: AR accepted at edge T -> rvalid high from edge T+1+RD_LAT.
REQ-018 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP; AW and W captured independently, either order or same cycle.
REQ-019 awready=1 in W_IDLE until AW captured; wready=1 in W_IDLE until W captured; each drops the cycle after its handshake.
REQ-020 When both captured: go W_WAIT (counter WR_LAT-1) if WR_LAT>0, else W_RESP directly.
REQ-021 Commit on the edge entering W_RESP: byte lane i written from wdata[8i+7:8i] iff wstrb[i]; no realignment (master pre-shifts).
REQ-022 bresp=OKAY; DECERR (no write) if awaddr out of range; SLVERR (no write) if awlen!=0 or wlast=0.
REQ-023 W_RESP: bvalid=1, bid=latched awid, held until bvalid&bready; then W_IDLE.
REQ-024 Read and write FSMs independent; concurrent transactions allowed.
REQ-025 Read sampling and write commit to same word on same edge: read returns old data.
REQ-026 wstrb=4'b0000 with in-range address: OKAY response, memory unchanged.
REQ-027 Address bits [1:0] ignored for memory indexing.

Reset
REQ-028 During reset: arready=awready=wready=0, rvalid=bvalid=0, rdata=0, rresp=bresp=0, rid=bid=0, rlast=0.
REQ-029 First cycle after reset deasserts: both FSMs in IDLE, arready=awready=wready=1.
REQ-030 Reset mid-transaction aborts it: no commit, no response; memory contents never reset.

Structure
REQ-031 Package ysyx_24080006_pkg SHALL hold AXI resp constants (OKAY, SLVERR, DECERR) and the read/write FSM state enums; axi_*_t types stay there.
REQ-032 Byte-enable memory array SHALL be sub-module ysyx_24080006_axi_sram_mem (one read port, one 4-lane write port, no reset).

Verification
REQ-033 Write 0xDEADBEEF, wstrb 4'b1111 @0x8000_0010, then read -> bresp OKAY, rdata 0xDEADBEEF, rlast=1.
REQ-034 Then write wdata 0x0000_5A00, wstrb 4'b0010 @0x8000_0011 -> read @0x8000_0010 returns 0xDEAD5AEF.
REQ-035 RD_LAT=3, AR accepted edge 10 -> rvalid at edge 14; rready held low 5 cycles -> rdata stable throughout.
REQ-036 W sent 2 cycles before AW -> wready drops after W handshake, bvalid at AW-capture edge +1+WR_LAT.
REQ-037 Read @0x7FFF_FFFC and write @0x8000_1000 (MEM_WORDS=1024) -> rresp/bresp 2'b11, rdata 0, memory unchanged.
REQ-038 Reset asserted in R_WAIT and W_WAIT -> no rvalid/bvalid; after reset readys=1; target word keeps old value.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - AXI response codes, FSM states and channel structs for the SRAM slave
package ysyx_24080006_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [3:0]  awid;
        logic [7:0]  awlen;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } axi_w_s2m_t;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

    // Decode error outranks a malformed (multi-beat) request.
    function automatic logic [1:0] axi_resp(input logic in_range, input logic single_beat);
        if (!in_range) return DECERR;
        if (!single_beat) return SLVERR;
        return OKAY;
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi_sram_if.sv
// rtl/ysyx_24080006_axi_sram_if.sv - bundles the four AXI channel groups of the SRAM slave
interface ysyx_24080006_axi_sram_if;
    import ysyx_24080006_pkg::*;

    axi_w_m2s_t w_m2s;
    axi_w_s2m_t w_s2m;
    axi_r_m2s_t r_m2s;
    axi_r_s2m_t r_s2m;

    modport master (
        output w_m2s,
        output r_m2s,
        input  w_s2m,
        input  r_s2m
    );

    modport slave (
        input  w_m2s,
        input  r_m2s,
        output w_s2m,
        output r_s2m
    );
endinterface

// File: rtl/ysyx_24080006_axi_sram_mem.sv
// rtl/ysyx_24080006_axi_sram_mem.sv - word array with combinational read and byte-lane write, never reset
module ysyx_24080006_axi_sram_mem #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clock,
    input  logic [$clog2(WORDS)-1:0] rd_idx,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(WORDS)-1:0] wr_idx,
    input  logic [3:0]               wr_strb,
    input  logic [31:0]              wr_data
);
    logic [31:0] mem [WORDS];

    // Read is combinational so a same-edge write is seen only on the next access.
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/ysyx_24080006_axi_sram.sv
// rtl/ysyx_24080006_axi_sram.sv - single-beat AXI SRAM slave with independent read and write FSMs
module ysyx_24080006_axi_sram
    import ysyx_24080006_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned WR_LAT    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_w_m2s_t w_m2s,
    output axi_w_s2m_t w_s2m,
    input  axi_r_m2s_t r_m2s,
    output axi_r_s2m_t r_s2m
);
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  RD_INIT   = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [3:0]  WR_INIT   = 4'((WR_LAT > 0) ? WR_LAT - 1 : 0);

    rd_state_t   rd_state, rd_next;
    logic        rd_load, arready, rd_in_range;
    logic [3:0]  rd_cnt, arid_q, rd_id, rid_q;
    logic [7:0]  arlen_q, rd_len;
    logic [31:0] araddr_q, rd_addr, rd_off, mem_rdata, rdata_q;
    logic [1:0]  rresp_q;

    wr_state_t   wr_state, wr_next;
    logic        wr_commit, awready, wready, aw_hs, w_hs, aw_have, w_have;
    logic        aw_done, w_done, wlast_q, wr_last, wr_in_range, wr_ok;
    logic [3:0]  wr_cnt, awid_q, wr_id, wstrb_q, wr_strb, bid_q;
    logic [7:0]  awlen_q, wr_len;
    logic [31:0] awaddr_q, wr_addr, wr_off, wdata_q, wr_data;
    logic [1:0]  bresp_q;

    // In R_IDLE the live AR fields are used so RD_LAT=0 can answer on the accept edge.
    assign arready     = (rd_state == R_IDLE) && !reset;
    assign rd_addr     = (rd_state == R_IDLE) ? r_m2s.araddr : araddr_q;
    assign rd_len      = (rd_state == R_IDLE) ? r_m2s.arlen  : arlen_q;
    assign rd_id       = (rd_state == R_IDLE) ? r_m2s.arid   : arid_q;
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = rd_off < MEM_BYTES;

    always_comb begin
        rd_next = rd_state;
        rd_load = 1'b0;
        case (rd_state)
            R_IDLE: if (r_m2s.arvalid) begin
                rd_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
                rd_load = (RD_LAT == 0);
            end
            R_WAIT: if (rd_cnt == 4'd0) begin
                rd_next = R_RESP;
                rd_load = 1'b1;
            end
            R_RESP: if (r_m2s.rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt   <= 4'd0;
            araddr_q <= 32'd0;
            arlen_q  <= 8'd0;
            arid_q   <= 4'd0;
            rdata_q  <= 32'd0;
            rresp_q  <= OKAY;
            rid_q    <= 4'd0;
        end else begin
            if (arready && r_m2s.arvalid) begin
                araddr_q <= r_m2s.araddr;
                arlen_q  <= r_m2s.arlen;
                arid_q   <= r_m2s.arid;
                rd_cnt   <= RD_INIT;
            end else if (rd_state == R_WAIT) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (rd_load) begin
                rresp_q <= axi_resp(rd_in_range, rd_len == 8'd0);
                rdata_q <= (rd_in_range && rd_len == 8'd0) ? mem_rdata : 32'd0;
                rid_q   <= rd_id;
            end
        end
    end

    // AW and W are captured independently; a channel not yet captured is taken live.
    assign awready     = (wr_state == W_IDLE) && !aw_done && !reset;
    assign wready      = (wr_state == W_IDLE) && !w_done && !reset;
    assign aw_hs       = awready && w_m2s.awvalid;
    assign w_hs        = wready && w_m2s.wvalid;
    assign aw_have     = aw_done || aw_hs;
    assign w_have      = w_done || w_hs;
    assign wr_addr     = aw_done ? awaddr_q : w_m2s.awaddr;
    assign wr_len      = aw_done ? awlen_q  : w_m2s.awlen;
    assign wr_id       = aw_done ? awid_q   : w_m2s.awid;
    assign wr_data     = w_done  ? wdata_q  : w_m2s.wdata;
    assign wr_strb     = w_done  ? wstrb_q  : w_m2s.wstrb;
    assign wr_last     = w_done  ? wlast_q  : w_m2s.wlast;
    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = wr_off < MEM_BYTES;
    assign wr_ok       = wr_in_range && (wr_len == 8'd0) && wr_last;

    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        case (wr_state)
            W_IDLE: if (aw_have && w_have) begin
                wr_next   = (WR_LAT == 0) ? W_RESP : W_WAIT;
                wr_commit = (WR_LAT == 0);
            end
            W_WAIT: if (wr_cnt == 4'd0) begin
                wr_next   = W_RESP;
                wr_commit = 1'b1;
            end
            W_RESP: if (w_m2s.bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awaddr_q <= 32'd0;
            awlen_q  <= 8'd0;
            awid_q   <= 4'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            wlast_q  <= 1'b0;
            wr_cnt   <= 4'd0;
            bresp_q  <= OKAY;
            bid_q    <= 4'd0;
        end else begin
            if (aw_hs) begin
                aw_done  <= 1'b1;
                awaddr_q <= w_m2s.awaddr;
                awlen_q  <= w_m2s.awlen;
                awid_q   <= w_m2s.awid;
            end
            if (w_hs) begin
                w_done  <= 1'b1;
                wdata_q <= w_m2s.wdata;
                wstrb_q <= w_m2s.wstrb;
                wlast_q <= w_m2s.wlast;
            end
            if (wr_state == W_IDLE && aw_have && w_have) wr_cnt <= WR_INIT;
            else if (wr_state == W_WAIT)                 wr_cnt <= wr_cnt - 4'd1;
            if (wr_commit) begin
                bresp_q <= axi_resp(wr_in_range, (wr_len == 8'd0) && wr_last);
                bid_q   <= wr_id;
            end
            if (wr_state == W_RESP && w_m2s.bready) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    ysyx_24080006_axi_sram_mem #(.WORDS(MEM_WORDS)) u_mem (
        .clock   (clock),
        .rd_idx  (rd_off[IDX_W+1:2]),
        .rd_data (mem_rdata),
        .wr_en   (wr_commit && wr_ok && !reset),
        .wr_idx  (wr_off[IDX_W+1:2]),
        .wr_strb (wr_strb),
        .wr_data (wr_data)
    );

    // Everything the master sees is forced quiet while reset is held.
    always_comb begin
        r_s2m = '0;
        w_s2m = '0;
        if (!reset) begin
            r_s2m.arready = arready;
            r_s2m.rvalid  = (rd_state == R_RESP);
            r_s2m.rdata   = rdata_q;
            r_s2m.rresp   = rresp_q;
            r_s2m.rlast   = (rd_state == R_RESP);
            r_s2m.rid     = rid_q;
            w_s2m.awready = awready;
            w_s2m.wready  = wready;
            w_s2m.bvalid  = (wr_state == W_RESP);
            w_s2m.bresp   = bresp_q;
            w_s2m.bid     = bid_q;
        end
    end
endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
// tb/tb_ysyx_24080006_axi_sram.sv - directed self-checking bench for the AXI SRAM slave
module tb_ysyx_24080006_axi_sram;
    import ysyx_24080006_pkg::*;

    localparam int unsigned RD_LAT = 3;
    localparam int unsigned WR_LAT = 2;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ysyx_24080006_axi_sram_if bus ();

    ysyx_24080006_axi_sram #(
        .MEM_WORDS (1024),
        .BASE_ADDR (32'h8000_0000),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .w_m2s (bus.w_m2s),
        .w_s2m (bus.w_s2m),
        .r_m2s (bus.r_m2s),
        .r_s2m (bus.r_s2m)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_b(input int aw_edge, output logic [1:0] resp, output logic [3:0] bid, output int lat);
        int guard = 0;
        bus.w_m2s.bready = 1'b1;
        while (!bus.w_s2m.bvalid && guard < 40) begin
            step();
            guard++;
        end
        check("bvalid_seen", 32'(bus.w_s2m.bvalid), 32'd1);
        resp = bus.w_s2m.bresp;
        bid  = bus.w_s2m.bid;
        lat  = cyc + 1 - aw_edge;
        step();
        bus.w_m2s.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] id, input logic [7:0] len, input logic last,
                            output logic [1:0] resp, output logic [3:0] bid, output int lat);
        int   guard = 0;
        int   aw_edge = 0;
        logic aw_fire, w_fire;
        bus.w_m2s.awaddr  = addr;
        bus.w_m2s.awid    = id;
        bus.w_m2s.awlen   = len;
        bus.w_m2s.wdata   = data;
        bus.w_m2s.wstrb   = strb;
        bus.w_m2s.wlast   = last;
        bus.w_m2s.awvalid = 1'b1;
        bus.w_m2s.wvalid  = 1'b1;
        while ((bus.w_m2s.awvalid || bus.w_m2s.wvalid) && guard < 40) begin
            aw_fire = bus.w_m2s.awvalid && bus.w_s2m.awready;
            w_fire  = bus.w_m2s.wvalid && bus.w_s2m.wready;
            step();
            guard++;
            if (aw_fire) begin
                bus.w_m2s.awvalid = 1'b0;
                aw_edge = cyc;
            end
            if (w_fire) bus.w_m2s.wvalid = 1'b0;
        end
        wait_b(aw_edge, resp, bid, lat);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input int hold,
                           output logic [31:0] data, output logic [1:0] resp, output logic [3:0] rid_o,
                           output logic last, output int lat, output logic stable);
        int guard = 0;
        int ar_edge;
        bus.r_m2s.araddr  = addr;
        bus.r_m2s.arid    = id;
        bus.r_m2s.arlen   = len;
        bus.r_m2s.rready  = 1'b0;
        bus.r_m2s.arvalid = 1'b1;
        while (!bus.r_s2m.arready && guard < 40) begin
            step();
            guard++;
        end
        step();
        bus.r_m2s.arvalid = 1'b0;
        ar_edge = cyc;
        while (!bus.r_s2m.rvalid && guard < 80) begin
            step();
            guard++;
        end
        check("rvalid_seen", 32'(bus.r_s2m.rvalid), 32'd1);
        lat    = cyc + 1 - ar_edge;
        data   = bus.r_s2m.rdata;
        resp   = bus.r_s2m.rresp;
        rid_o  = bus.r_s2m.rid;
        last   = bus.r_s2m.rlast;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (bus.r_s2m.rvalid !== 1'b1 || bus.r_s2m.rdata !== data ||
                bus.r_s2m.rresp !== resp || bus.r_s2m.rid !== rid_o) stable = 1'b0;
        end
        bus.r_m2s.rready = 1'b1;
        step();
        bus.r_m2s.rready = 1'b0;
    endtask

    logic [31:0] d;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last, stable, quiet;
    int          lat, aw_edge;

    initial begin
        bus.w_m2s = '0;
        bus.r_m2s = '0;
        reset = 1'b1;
        step();
        step();
        check("rst_arready", 32'(bus.r_s2m.arready), 32'd0);
        check("rst_awready", 32'(bus.w_s2m.awready), 32'd0);
        check("rst_wready",  32'(bus.w_s2m.wready),  32'd0);
        check("rst_rvalid",  32'(bus.r_s2m.rvalid),  32'd0);
        check("rst_bvalid",  32'(bus.w_s2m.bvalid),  32'd0);
        check("rst_rdata",   bus.r_s2m.rdata,        32'd0);
        check("rst_rlast",   32'(bus.r_s2m.rlast),   32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_arready", 32'(bus.r_s2m.arready), 32'd1);
        check("post_rst_awready", 32'(bus.w_s2m.awready), 32'd1);
        check("post_rst_wready",  32'(bus.w_s2m.wready),  32'd1);

        // Full-word write then read back
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h3, 8'd0, 1'b1, resp, id, lat);
        check("wr1_bresp", 32'(resp), 32'h0);
        check("wr1_bid",   32'(id),   32'h3);
        check("wr1_lat",   32'(lat),  32'd3);
        do_read(32'h8000_0010, 4'h5, 8'd0, 0, d, resp, id, last, lat, stable);
        check("rd1_rdata", d,          32'hDEAD_BEEF);
        check("rd1_rresp", 32'(resp),  32'h0);
        check("rd1_rlast", 32'(last),  32'd1);
        check("rd1_rid",   32'(id),    32'h5);
        check("rd1_lat",   32'(lat),   32'd4);
        check("rd1_rvalid_drop", 32'(bus.r_s2m.rvalid), 32'd0);

        // Single byte lane, unaligned address
        do_write(32'h8000_0011, 32'h0000_5A00, 4'b0010, 4'h1, 8'd0, 1'b1, resp, id, lat);
        check("wr2_bresp", 32'(resp), 32'h0);
        do_read(32'h8000_0010, 4'h2, 8'd0, 5, d, resp, id, last, lat, stable);
        check("rd2_rdata",  d,            32'hDEAD_5AEF);
        check("rd2_stable", 32'(stable),  32'd1);
        check("rd2_lat",    32'(lat),     32'd4);

        // W two cycles ahead of AW
        bus.w_m2s.wdata  = 32'h1234_5678;
        bus.w_m2s.wstrb  = 4'hF;
        bus.w_m2s.wlast  = 1'b1;
        bus.w_m2s.wvalid = 1'b1;
        step();
        bus.w_m2s.wvalid = 1'b0;
        check("wfirst_wready_drop", 32'(bus.w_s2m.wready),  32'd0);
        check("wfirst_awready",     32'(bus.w_s2m.awready), 32'd1);
        step();
        step();
        bus.w_m2s.awaddr  = 32'h8000_0020;
        bus.w_m2s.awid    = 4'h7;
        bus.w_m2s.awlen   = 8'd0;
        bus.w_m2s.awvalid = 1'b1;
        step();
        bus.w_m2s.awvalid = 1'b0;
        aw_edge = cyc;
        wait_b(aw_edge, resp, id, lat);
        check("wfirst_lat",   32'(lat),  32'd3);
        check("wfirst_bresp", 32'(resp), 32'h0);
        check("wfirst_bid",   32'(id),   32'h7);
        do_read(32'h8000_0020, 4'h0, 8'd0, 0, d, resp, id, last, lat, stable);
        check("wfirst_readback", d, 32'h1234_5678);

        // Out-of-range accesses must not alias onto word 0
        do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 4'h0, 8'd0, 1'b1, resp, id, lat);
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 4'h0, 8'd0, 1'b1, resp, id, lat);
        check("oor_bresp", 32'(resp), 32'h3);
        do_read(32'h7FFF_FFFC, 4'h9, 8'd0, 0, d, resp, id, last, lat, stable);
        check("oor_rresp", 32'(resp), 32'h3);
        check("oor_rdata", d,         32'h0);
        do_read(32'h8000_0000, 4'h0, 8'd0, 0, d, resp, id, last, lat, stable);
        check("oor_word0_kept", d, 32'hCAFE_F00D);

        // Burst requests and missing wlast are rejected without writing
        do_write(32'h8000_0000, 32'h0BAD_BAD0, 4'hF, 4'h0, 8'd1, 1'b1, resp, id, lat);
        check("awlen_slverr", 32'(resp), 32'h2);
        do_write(32'h8000_0000, 32'h0BAD_BAD0, 4'hF, 4'h0, 8'd0, 1'b0, resp, id, lat);
        check("wlast_slverr", 32'(resp), 32'h2);
        do_read(32'h8000_0000, 4'h0, 8'd3, 0, d, resp, id, last, lat, stable);
        check("arlen_slverr", 32'(resp), 32'h2);
        do_write(32'h8000_0000, 32'h0BAD_BAD0, 4'h0, 4'h0, 8'd0, 1'b1, resp, id, lat);
        check("strb0_bresp", 32'(resp), 32'h0);
        do_read(32'h8000_0000, 4'h0, 8'd0, 0, d, resp, id, last, lat, stable);
        check("err_word0_kept", d, 32'hCAFE_F00D);

        // Read sample and write commit on the same edge: read sees old data
        do_write(32'h8000_0030, 32'hAAAA_AAAA, 4'hF, 4'h1, 8'd0, 1'b1, resp, id, lat);
        bus.r_m2s.araddr  = 32'h8000_0030;
        bus.r_m2s.arid    = 4'h2;
        bus.r_m2s.arlen   = 8'd0;
        bus.r_m2s.rready  = 1'b1;
        bus.r_m2s.arvalid = 1'b1;
        step();
        bus.r_m2s.arvalid = 1'b0;
        bus.w_m2s.awaddr  = 32'h8000_0030;
        bus.w_m2s.awid    = 4'h4;
        bus.w_m2s.awlen   = 8'd0;
        bus.w_m2s.wdata   = 32'h5555_5555;
        bus.w_m2s.wstrb   = 4'hF;
        bus.w_m2s.wlast   = 1'b1;
        bus.w_m2s.bready  = 1'b1;
        bus.w_m2s.awvalid = 1'b1;
        bus.w_m2s.wvalid  = 1'b1;
        step();
        bus.w_m2s.awvalid = 1'b0;
        bus.w_m2s.wvalid  = 1'b0;
        for (int g = 0; g < 20 && !bus.r_s2m.rvalid; g++) step();
        check("same_edge_old_data", bus.r_s2m.rdata,          32'hAAAA_AAAA);
        check("same_edge_bvalid",   32'(bus.w_s2m.bvalid),    32'd1);
        step();
        bus.r_m2s.rready = 1'b0;
        bus.w_m2s.bready = 1'b0;
        do_read(32'h8000_0030, 4'h0, 8'd0, 0, d, resp, id, last, lat, stable);
        check("same_edge_new_data", d, 32'h5555_5555);

        // Reset while both FSMs are waiting aborts both transactions
        bus.r_m2s.araddr  = 32'h8000_0000;
        bus.r_m2s.arid    = 4'h1;
        bus.r_m2s.arlen   = 8'd0;
        bus.r_m2s.arvalid = 1'b1;
        bus.w_m2s.awaddr  = 32'h8000_0000;
        bus.w_m2s.awid    = 4'h1;
        bus.w_m2s.awlen   = 8'd0;
        bus.w_m2s.wdata   = 32'h1111_1111;
        bus.w_m2s.wstrb   = 4'hF;
        bus.w_m2s.wlast   = 1'b1;
        bus.w_m2s.awvalid = 1'b1;
        bus.w_m2s.wvalid  = 1'b1;
        step();
        bus.r_m2s.arvalid = 1'b0;
        bus.w_m2s.awvalid = 1'b0;
        bus.w_m2s.wvalid  = 1'b0;
        reset = 1'b1;
        step();
        check("midrst_rvalid",  32'(bus.r_s2m.rvalid),  32'd0);
        check("midrst_bvalid",  32'(bus.w_s2m.bvalid),  32'd0);
        check("midrst_arready", 32'(bus.r_s2m.arready), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("midrst_arready_after", 32'(bus.r_s2m.arready), 32'd1);
        check("midrst_awready_after", 32'(bus.w_s2m.awready), 32'd1);
        check("midrst_wready_after",  32'(bus.w_s2m.wready),  32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.r_s2m.rvalid || bus.w_s2m.bvalid) quiet = 1'b0;
        end
        check("midrst_no_response", 32'(quiet), 32'd1);
        do_read(32'h8000_0000, 4'h0, 8'd0, 0, d, resp, id, last, lat, stable);
        check("midrst_word_kept", d, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
